spi_slave_to_ctrlport_master: RTL and testbench

CPLD-side SPI slave that terminates the 64-bit control-port-over-SPI frame and issues the decoded request on a control-port master interface. It oversamples ss/sclk/mosi in the ctrlport_clk domain, so the whole block runs on a single clock. It returns the read data, ack and status in the same frame.

---
 rtl/spi_slave_to_ctrlport_master.sv | 244 ++++++++++++++++++++++++
 tb/tb_spi_slave_to_ctrlport_master.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_to_ctrlport_master.sv
// SPI slave terminating the 64-bit control-port frame and driving a ctrlport master.
// Optional saturating error counter built when SPI_SLAVE_ERR_CNT_EN is defined.
module spi_slave_to_ctrlport_master #(
    parameter logic [4:0] ADDR_PREFIX = 5'b00000,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        ctrlport_clk,
    input  logic        ctrlport_rst,
    input  logic        ss,
    input  logic        sclk,
    input  logic        mosi,
    output logic        miso,
    output logic        m_ctrlport_req_wr,
    output logic        m_ctrlport_req_rd,
    output logic [19:0] m_ctrlport_req_addr,
    output logic [31:0] m_ctrlport_req_data,
    input  logic        m_ctrlport_resp_ack,
    input  logic [1:0]  m_ctrlport_resp_status,
    input  logic [31:0] m_ctrlport_resp_data,
    output logic [15:0] err_count,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HEADER    = 3'd1,
        ST_WR_DATA   = 3'd2,
        ST_WAIT_RD   = 3'd3,
        ST_WAIT_WR   = 3'd4,
        ST_SHIFT_OUT = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_ss_d;
    logic                   r_sclk_d;

    state_t      r_state;
    logic [5:0]  r_bit_cnt;
    logic [45:0] r_rx;
    logic [39:0] r_resp;
    logic        r_miso;
    logic        r_req_wr;
    logic        r_req_rd;
    logic [19:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_outstanding;
    logic        r_mine;
    logic        r_got_ack;
    logic [31:0] r_rdata;
    logic [1:0]  r_status;

    logic        w_ss;
    logic        w_sclk;
    logic        w_mosi;
    logic        w_ss_fall;
    logic        w_sclk_rise;
    logic        w_sclk_fall;
    logic        w_active;
    logic        w_abort;
    logic        w_deadline;
    logic        w_ack_now;
    logic        w_ack_ok;
    logic [31:0] w_rdata;
    logic [1:0]  w_status;
    logic [39:0] w_resp_word;

    always_ff @(posedge ctrlport_clk or posedge ctrlport_rst) begin
        if (ctrlport_rst) begin
            r_ss_sync   <= '1;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_ss_d      <= 1'b1;
            r_sclk_d    <= 1'b0;
        end else begin
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_ss_d      <= w_ss;
            r_sclk_d    <= w_sclk;
        end
    end

    assign w_ss        = r_ss_sync[SYNC_STAGES-1];
    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_ss_fall   = r_ss_d & ~w_ss;
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;

    assign w_active = (r_state == ST_HEADER) || (r_state == ST_WR_DATA) ||
                      (r_state == ST_WAIT_RD) || (r_state == ST_WAIT_WR) ||
                      (r_state == ST_SHIFT_OUT);
    assign w_abort  = w_active & w_ss;

    // Deadline is the falling edge that launches the first response bit of the frame type.
    assign w_deadline = ~w_ss & w_sclk_fall &
                        (((r_state == ST_WAIT_RD) && (r_bit_cnt == 6'd24)) ||
                         ((r_state == ST_WAIT_WR) && (r_bit_cnt == 6'd61)));

    // Only an ack for this frame's own request is reported; an ack on the deadline cycle counts.
    assign w_ack_now = m_ctrlport_resp_ack & r_mine;
    assign w_ack_ok  = r_got_ack | w_ack_now;
    assign w_rdata   = r_got_ack ? r_rdata  : (w_ack_now ? m_ctrlport_resp_data   : 32'h0);
    assign w_status  = r_got_ack ? r_status : (w_ack_now ? m_ctrlport_resp_status : 2'b00);

    assign w_resp_word = (r_state == ST_WAIT_RD) ? {w_rdata, 5'b00000, w_ack_ok, w_status}
                                                 : {w_ack_ok, w_status, 37'h0};

    always_ff @(posedge ctrlport_clk or posedge ctrlport_rst) begin
        if (ctrlport_rst) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= 6'd0;
            r_rx          <= '0;
            r_resp        <= '0;
            r_miso        <= 1'b0;
            r_req_wr      <= 1'b0;
            r_req_rd      <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_outstanding <= 1'b0;
            r_mine        <= 1'b0;
            r_got_ack     <= 1'b0;
            r_rdata       <= '0;
            r_status      <= '0;
        end else begin
            r_req_wr <= 1'b0;
            r_req_rd <= 1'b0;

            if (m_ctrlport_resp_ack) begin
                r_outstanding <= 1'b0;
            end

            if (w_ss) begin
                r_bit_cnt <= 6'd0;
            end else if (w_sclk_rise && w_active) begin
                r_bit_cnt <= r_bit_cnt + 6'd1;
                r_rx      <= {r_rx[44:0], w_mosi};
            end

            if (w_ack_now && !r_got_ack) begin
                r_got_ack <= 1'b1;
                r_rdata   <= m_ctrlport_resp_data;
                r_status  <= m_ctrlport_resp_status;
            end

            if (w_abort) begin
                r_state <= ST_IDLE;
                r_mine  <= 1'b0;
                r_miso  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_miso    <= 1'b0;
                        r_mine    <= 1'b0;
                        r_got_ack <= 1'b0;
                        if (w_ss_fall) begin
                            r_state <= ST_HEADER;
                        end
                    end
                    ST_HEADER: begin
                        if (w_sclk_rise && (r_bit_cnt == 6'd15)) begin
                            if (r_rx[14]) begin
                                r_state <= ST_WR_DATA;
                            end else begin
                                r_state <= ST_WAIT_RD;
                                if (!r_outstanding) begin
                                    r_req_rd      <= 1'b1;
                                    r_outstanding <= 1'b1;
                                    r_mine        <= 1'b1;
                                    r_addr        <= {ADDR_PREFIX, r_rx[13:0], w_mosi};
                                end
                            end
                        end
                    end
                    ST_WR_DATA: begin
                        if (w_sclk_rise && (r_bit_cnt == 6'd47)) begin
                            r_state <= ST_WAIT_WR;
                            if (!r_outstanding) begin
                                r_req_wr      <= 1'b1;
                                r_outstanding <= 1'b1;
                                r_mine        <= 1'b1;
                                r_addr        <= {ADDR_PREFIX, r_rx[45:31]};
                                r_wdata       <= {r_rx[30:0], w_mosi};
                            end
                        end
                    end
                    ST_WAIT_RD, ST_WAIT_WR: begin
                        if (w_deadline) begin
                            r_miso  <= w_resp_word[39];
                            r_resp  <= {w_resp_word[38:0], 1'b0};
                            r_mine  <= 1'b0;
                            r_state <= ST_SHIFT_OUT;
                        end
                    end
                    ST_SHIFT_OUT: begin
                        if (w_sclk_fall) begin
                            r_miso <= r_resp[39];
                            r_resp <= {r_resp[38:0], 1'b0};
                            if (r_bit_cnt == 6'd63) begin
                                r_state <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (w_ss) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef SPI_SLAVE_ERR_CNT_EN
    logic [15:0] r_err_count;
    logic        w_err_event;

    assign w_err_event = w_abort | (w_deadline & ~w_ack_ok);

    always_ff @(posedge ctrlport_clk or posedge ctrlport_rst) begin
        if (ctrlport_rst) begin
            r_err_count <= 16'h0;
        end else if (w_err_event && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'h1;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = 16'h0;
`endif

    assign miso                = r_miso & ~ss;
    assign m_ctrlport_req_wr   = r_req_wr;
    assign m_ctrlport_req_rd   = r_req_rd;
    assign m_ctrlport_req_addr = r_addr;
    assign m_ctrlport_req_data = r_wdata;
    assign dbg_state           = r_state;

endmodule

// File: tb/tb_spi_slave_to_ctrlport_master.sv
// Self-checking bench for spi_slave_to_ctrlport_master: frames are driven as an SPI
// master and checked against a frame-level model of responses, strobes and errors.
module tb_spi_slave_to_ctrlport_master;

`ifdef SPI_SLAVE_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        ss;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic        m_ctrlport_req_wr;
    logic        m_ctrlport_req_rd;
    logic [19:0] m_ctrlport_req_addr;
    logic [31:0] m_ctrlport_req_data;
    logic        m_ctrlport_resp_ack;
    logic [1:0]  m_ctrlport_resp_status;
    logic [31:0] m_ctrlport_resp_data;
    logic [15:0] err_count;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // responder / monitor state
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [19:0] last_addr = '0;
    logic [31:0] last_data = '0;
    bit          resp_en = 1'b0;
    int          resp_delay = 1;
    logic [31:0] resp_rdata = '0;
    logic [1:0]  resp_status = '0;
    int          pending = 0;
    bit          late_ack_req = 1'b0;

    // frame-level model
    bit m_outstanding = 1'b0;
    int m_err = 0;

    spi_slave_to_ctrlport_master dut (
        .ctrlport_clk           (clk),
        .ctrlport_rst           (rst),
        .ss                     (ss),
        .sclk                   (sclk),
        .mosi                   (mosi),
        .miso                   (miso),
        .m_ctrlport_req_wr      (m_ctrlport_req_wr),
        .m_ctrlport_req_rd      (m_ctrlport_req_rd),
        .m_ctrlport_req_addr    (m_ctrlport_req_addr),
        .m_ctrlport_req_data    (m_ctrlport_req_data),
        .m_ctrlport_resp_ack    (m_ctrlport_resp_ack),
        .m_ctrlport_resp_status (m_ctrlport_resp_status),
        .m_ctrlport_resp_data   (m_ctrlport_resp_data),
        .err_count              (err_count),
        .dbg_state              (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ctrlport slave: counts strobes and answers after resp_delay cycles when enabled.
    initial begin : responder
        m_ctrlport_resp_ack    = 1'b0;
        m_ctrlport_resp_status = 2'b00;
        m_ctrlport_resp_data   = 32'h0;
        forever begin
            @(negedge clk);
            m_ctrlport_resp_ack    = 1'b0;
            m_ctrlport_resp_status = 2'($urandom);
            m_ctrlport_resp_data   = $urandom;
            if (late_ack_req) begin
                m_ctrlport_resp_ack = 1'b1;
                late_ack_req        = 1'b0;
            end else if (pending > 0) begin
                pending = pending - 1;
                if (pending == 0) begin
                    m_ctrlport_resp_ack    = 1'b1;
                    m_ctrlport_resp_data   = resp_rdata;
                    m_ctrlport_resp_status = resp_status;
                end
            end
            if (m_ctrlport_req_wr || m_ctrlport_req_rd) begin
                if (m_ctrlport_req_wr) wr_cnt++;
                if (m_ctrlport_req_rd) rd_cnt++;
                last_addr = m_ctrlport_req_addr;
                last_data = m_ctrlport_req_data;
                if (resp_en) pending = resp_delay;
            end
        end
    end

    function automatic logic [15:0] exp_err();
        return ERR_EN ? 16'(m_err) : 16'h0;
    endfunction

    // SPI mode-0 master: miso is sampled just before each rising edge.
    task automatic spi_xfer(input logic [63:0] tx, input int nbits, input int half,
                            output logic [63:0] rx);
        rx   = '0;
        ss   = 1'b0;
        sclk = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[63-i];
            repeat (half) @(negedge clk);
            rx[63-i] = miso;
            sclk = 1'b1;
            repeat (half) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (half) @(negedge clk);
    endtask

    task automatic late_ack();
        late_ack_req = 1'b1;
        repeat (3) @(negedge clk);
        m_outstanding = 1'b0;
    endtask

    task automatic run_frame(input bit wr, input logic [14:0] addr, input logic [31:0] wdata,
                             input bit ack_en, input int delay, input logic [31:0] rdata,
                             input logic [1:0] status, input string name);
        logic [63:0] tx, rx, exp_rx;
        bit          exp_strobe, exp_ack;
        int          wr0, rd0;
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        resp_en     = ack_en;
        resp_delay  = delay;
        resp_rdata  = rdata;
        resp_status = status;

        exp_strobe = !m_outstanding;
        exp_ack    = exp_strobe && ack_en;
        if (exp_strobe) m_outstanding = !ack_en;
        if (!exp_ack) m_err++;
        if (wr)
            exp_rx = {61'h0, exp_ack, exp_ack ? status : 2'b00};
        else
            exp_rx = {24'h0, exp_ack ? rdata : 32'h0, 5'h0, exp_ack, exp_ack ? status : 2'b00};

        if (wr) tx = {1'b1, addr, wdata, 16'($urandom)};
        else    tx = {1'b0, addr, $urandom, 16'($urandom)};

        spi_xfer(tx, 64, $urandom_range(4, 8), rx);
        ss = 1'b1;
        repeat (10) @(negedge clk);
        resp_en = 1'b0;

        n_checks++;
        if (rx !== exp_rx) begin
            n_fail++;
            $display("FAIL %s miso: got %h expected %h", name, rx, exp_rx);
        end
        n_checks++;
        if ((wr_cnt - wr0) !== ((wr && exp_strobe) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s wr_strobes: got %0d expected %0d", name, wr_cnt - wr0,
                     (wr && exp_strobe) ? 1 : 0);
        end
        n_checks++;
        if ((rd_cnt - rd0) !== ((!wr && exp_strobe) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s rd_strobes: got %0d expected %0d", name, rd_cnt - rd0,
                     (!wr && exp_strobe) ? 1 : 0);
        end
        if (exp_strobe) begin
            n_checks++;
            if (last_addr !== {5'b00000, addr}) begin
                n_fail++;
                $display("FAIL %s req_addr: got %h expected %h", name, last_addr, {5'b00000, addr});
            end
            if (wr) begin
                n_checks++;
                if (last_data !== wdata) begin
                    n_fail++;
                    $display("FAIL %s req_data: got %h expected %h", name, last_data, wdata);
                end
            end
        end
        n_checks++;
        if (err_count !== exp_err()) begin
            n_fail++;
            $display("FAIL %s err_count: got %0d expected %0d", name, err_count, exp_err());
        end
        n_checks++;
        if (dbg_state !== 3'd0) begin
            n_fail++;
            $display("FAIL %s end_state: got %0d expected 0", name, dbg_state);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({miso, m_ctrlport_req_wr, m_ctrlport_req_rd} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_bits: got %b expected 000",
                     {miso, m_ctrlport_req_wr, m_ctrlport_req_rd});
        end
        n_checks++;
        if (m_ctrlport_req_addr !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_addr: got %h expected 00000", m_ctrlport_req_addr);
        end
        n_checks++;
        if (m_ctrlport_req_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", m_ctrlport_req_data);
        end
        n_checks++;
        if (err_count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_err_count: got %0d expected 0", err_count);
        end
        n_checks++;
        if (dbg_state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected 0", dbg_state);
        end
    endtask

    task automatic test_write_basic();
        run_frame(1'b1, 15'h0123, 32'hDEADBEEF, 1'b1, 3, 32'h0, 2'b00, "write_basic");
    endtask

    task automatic test_read_basic();
        run_frame(1'b0, 15'h7FFF, 32'h0, 1'b1, 2, 32'hCAFEF00D, 2'b01, "read_basic");
    endtask

    task automatic test_read_no_ack();
        run_frame(1'b0, 15'h0042, 32'h0, 1'b0, 1, 32'h0, 2'b00, "read_no_ack");
        late_ack();
        run_frame(1'b0, 15'h0043, 32'h0, 1'b1, 4, 32'h12345678, 2'b10, "read_after_late_ack");
    endtask

    task automatic test_no_ack_then_write();
        run_frame(1'b0, 15'h0100, 32'h0, 1'b0, 1, 32'h0, 2'b00, "read_no_ack2");
        run_frame(1'b1, 15'h0101, 32'hA5A5A5A5, 1'b1, 2, 32'h0, 2'b11, "write_blocked");
        late_ack();
        run_frame(1'b1, 15'h0102, 32'h5A5A5A5A, 1'b1, 2, 32'h0, 2'b11, "write_after_clear");
    endtask

    task automatic test_abort();
        logic [63:0] rx;
        int          wr0, rd0;
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        resp_en = 1'b1;
        spi_xfer({1'b1, 15'h0ABC, 32'h11223344, 16'h0}, 21, 5, rx);
        ss = 1'b1;
        repeat (10) @(negedge clk);
        resp_en = 1'b0;
        m_err++;
        n_checks++;
        if ((wr_cnt - wr0) + (rd_cnt - rd0) !== 0) begin
            n_fail++;
            $display("FAIL abort_strobes: got %0d expected 0", (wr_cnt - wr0) + (rd_cnt - rd0));
        end
        n_checks++;
        if (dbg_state !== 3'd0) begin
            n_fail++;
            $display("FAIL abort_state: got %0d expected 0", dbg_state);
        end
        n_checks++;
        if (err_count !== exp_err()) begin
            n_fail++;
            $display("FAIL abort_err_count: got %0d expected %0d", err_count, exp_err());
        end
        run_frame(1'b1, 15'h0ABC, 32'h11223344, 1'b1, 5, 32'h0, 2'b01, "write_after_abort");
    endtask

    task automatic test_reset_mid_frame();
        logic [63:0] rx;
        int          rd0;
        rd0 = rd_cnt;
        resp_en     = 1'b1;
        resp_delay  = 2;
        resp_rdata  = 32'hFFFFFFFF;
        resp_status = 2'b11;
        spi_xfer({1'b0, 15'h1357, 48'h0}, 40, 5, rx);
        resp_en = 1'b0;
        n_checks++;
        if (miso !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_miso: got %b expected 1", miso);
        end
        n_checks++;
        if ((rd_cnt - rd0) !== 1) begin
            n_fail++;
            $display("FAIL midframe_rd_strobes: got %0d expected 1", rd_cnt - rd0);
        end
        rst = 1'b1;
        #1;
        test_reset();
        ss   = 1'b1;
        sclk = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_outstanding = 1'b0;
        m_err = 0;
        repeat (3) @(negedge clk);
        run_frame(1'b0, 15'h2468, 32'h0, 1'b1, 3, 32'h0BADF00D, 2'b10, "read_after_reset");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            run_frame(1'($urandom), 15'($urandom), $urandom, ($urandom_range(0, 4) != 0),
                      $urandom_range(1, 20), $urandom, 2'($urandom), "random");
            if (m_outstanding && ($urandom_range(0, 1) == 1)) late_ack();
        end
        if (m_outstanding) late_ack();
    endtask

    initial begin
        rst  = 1'b1;
        ss   = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_write_basic();
        test_read_basic();
        test_read_no_ack();
        test_no_ack_then_write();
        test_abort();
        test_reset_mid_frame();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
